// File: rtl/vx_uop_expander.sv
// vx_uop_expander: per-warp micro-op sequencer.
// Expands each instruction into 1..MAX_UOPS micro-ops. Each micro-op carries a running
// destination register offset. The first micro-op leaves combinationally in the cycle
// the instruction is accepted, and the instruction buffer is released at that moment.
module vx_uop_expander #(
   parameter int DATA_WIDTH   = 64,
   parameter int MAX_UOPS     = 16,
   parameter int REG_WIDTH    = 6,
   parameter int STRIDE_WIDTH = 3,
   parameter int CNT_WIDTH    = $clog2(MAX_UOPS + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [CNT_WIDTH-1:0]    in_count,
   input  logic [REG_WIDTH-1:0]    in_rd,
   input  logic [STRIDE_WIDTH-1:0] in_stride,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [REG_WIDTH-1:0]    out_rd,
   output logic [CNT_WIDTH-1:0]    out_idx,
   output logic                    out_first,
   output logic                    out_last,
   output logic                    busy
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_UOPS);

   // Requested count -> effective count: 0 behaves as 1, oversize requests clamp silently.
   function automatic logic [CNT_WIDTH-1:0] clamp_count(input logic [CNT_WIDTH-1:0] c);
      if (c == '0)
         return CNT_ONE;
      else if (c > CNT_MAX)
         return CNT_MAX;
      else
         return c;
   endfunction

   // Register index advance: zero-extended stride, wraps modulo 2^REG_WIDTH.
   function automatic logic [REG_WIDTH-1:0] rd_step(input logic [REG_WIDTH-1:0]    rd,
                                                     input logic [STRIDE_WIDTH-1:0] stride);
      return rd + REG_WIDTH'(stride);
   endfunction

   state_t                  state;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [REG_WIDTH-1:0]    rd_q;
   logic [STRIDE_WIDTH-1:0] stride_q;
   logic [CNT_WIDTH-1:0]    last_idx_q;
   logic [CNT_WIDTH-1:0]    idx_q;

   logic [CNT_WIDTH-1:0]    n_eff;
   logic                    fire;
   logic                    start;
   logic                    advance;

   assign n_eff   = clamp_count(in_count);
   assign fire    = out_valid & out_ready;
   assign start   = (state == IDLE) & fire & (n_eff != CNT_ONE);
   assign advance = (state == ACTIVE) & fire & ~out_last;
   assign busy    = (state == ACTIVE);

   // Output mux: IDLE passes the input straight through; ACTIVE replays the latched instruction.
   always_comb begin
      out_valid = 1'b0;
      in_ready  = 1'b0;
      out_data  = in_data;
      out_rd    = in_rd;
      out_idx   = '0;
      out_first = 1'b1;
      out_last  = (n_eff == CNT_ONE);
      if (state == ACTIVE) begin
         out_valid = 1'b1;
         out_data  = data_q;
         out_rd    = rd_q;
         out_idx   = idx_q;
         out_first = 1'b0;
         out_last  = (idx_q == last_idx_q);
      end else begin
         out_valid = in_valid;
         in_ready  = out_ready;
      end
      // Reset and flush block any handshake in the cycle they are asserted.
      if (reset || flush) begin
         out_valid = 1'b0;
         in_ready  = 1'b0;
      end
   end

   // Sequencer state and micro-op index; reset and flush both drop back to IDLE.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state <= IDLE;
         idx_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= ACTIVE;
                  idx_q <= CNT_ONE;
               end
            end
            ACTIVE: begin
               if (fire) begin
                  if (out_last) begin
                     state <= IDLE;
                     idx_q <= '0;
                  end else begin
                     idx_q <= idx_q + CNT_ONE;
                  end
               end
            end
            default: begin
               state <= IDLE;
               idx_q <= '0;
            end
         endcase
      end
   end

   // Instruction capture and running rd; these are only consumed while ACTIVE, so they carry no reset.
   always_ff @(posedge clk) begin
      if (start) begin
         data_q     <= in_data;
         stride_q   <= in_stride;
         last_idx_q <= n_eff - CNT_ONE;
         rd_q       <= rd_step(in_rd, in_stride);
      end else if (advance) begin
         rd_q       <= rd_step(rd_q, stride_q);
      end
   end

endmodule

// File: tb/tb_vx_uop_expander.sv
// tb_vx_uop_expander: scoreboard bench for vx_uop_expander.
// Instructions go into a stimulus queue; the micro-ops they should produce go into a
// scoreboard. Each transfer pops the scoreboard, and the popped entry is compared field by field.
module tb_vx_uop_expander;

   localparam int DW = 64;
   localparam int MU = 16;
   localparam int RW = 6;
   localparam int SW = 3;
   localparam int CW = $clog2(MU + 1);

   logic          clk = 1'b0;
   logic          reset, flush;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] in_count, out_idx;
   logic [RW-1:0] in_rd, out_rd;
   logic [SW-1:0] in_stride;
   logic          out_first, out_last, busy;

   always #5 clk = ~clk;

   vx_uop_expander #(
      .DATA_WIDTH(DW), .MAX_UOPS(MU), .REG_WIDTH(RW), .STRIDE_WIDTH(SW)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_count(in_count), .in_rd(in_rd), .in_stride(in_stride),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_rd(out_rd), .out_idx(out_idx), .out_first(out_first),
      .out_last(out_last), .busy(busy)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [CW-1:0] cnt;
      logic [RW-1:0] rd;
      logic [SW-1:0] stride;
   } instr_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [RW-1:0] rd;
      logic [CW-1:0] idx;
      logic          first;
      logic          last;
   } uop_t;

   instr_t iq[$];
   uop_t   sb[$];
   int     n_cmp  = 0;
   int     n_bad  = 0;
   int     n_xfer = 0;
   logic   s_ov, s_ir, s_busy, s_fire;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Queue an instruction and the micro-ops it must produce.
   task automatic send(input int cnt, input int rd, input int stride);
      instr_t t;
      uop_t   u;
      int     n;
      t.data   = {$urandom, $urandom};
      t.cnt    = cnt[CW-1:0];
      t.rd     = rd[RW-1:0];
      t.stride = stride[SW-1:0];
      iq.push_back(t);
      n = (cnt == 0) ? 1 : ((cnt > MU) ? MU : cnt);
      for (int i = 0; i < n; i++) begin
         u.data  = t.data;
         u.rd    = RW'(rd + i * stride);
         u.idx   = CW'(i);
         u.first = (i == 0);
         u.last  = (i == n - 1);
         sb.push_back(u);
      end
   endtask

   // One clock: drive the head instruction, sample #1 later, score, then wait for the next negedge.
   task automatic step();
      uop_t u;
      if (iq.size() > 0) begin
         in_valid  = 1'b1;
         in_data   = iq[0].data;
         in_count  = iq[0].cnt;
         in_rd     = iq[0].rd;
         in_stride = iq[0].stride;
      end else begin
         in_valid  = 1'b0;
         in_data   = '0;
         in_count  = '0;
         in_rd     = '0;
         in_stride = '0;
      end
      #1;
      s_ov   = out_valid;
      s_ir   = in_ready;
      s_busy = busy;
      s_fire = out_valid && out_ready;
      if (s_fire) begin
         n_xfer++;
         if (sb.size() == 0) begin
            chk("unexpected_xfer", 64'd1, 64'd0);
         end else begin
            u = sb.pop_front();
            chk("data",  out_data,        u.data);
            chk("rd",    64'(out_rd),     64'(u.rd));
            chk("idx",   64'(out_idx),    64'(u.idx));
            chk("first", 64'(out_first),  64'(u.first));
            chk("last",  64'(out_last),   64'(u.last));
         end
      end else if (out_valid && sb.size() > 0) begin
         chk("stall_data", out_data,     sb[0].data);
         chk("stall_rd",   64'(out_rd),  64'(sb[0].rd));
         chk("stall_idx",  64'(out_idx), 64'(sb[0].idx));
      end
      if (in_valid && in_ready)
         void'(iq.pop_front());
      // An abort while sequencing discards the rest of the current instruction.
      if ((flush || reset) && busy === 1'b1) begin
         while (sb.size() > 0) begin
            u = sb.pop_front();
            if (u.last) break;
         end
      end
      @(negedge clk);
   endtask

   logic rs [5];

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_count  = '0;
      in_rd     = '0;
      in_stride = '0;

      // Reset: handshakes forced low even with valid input and ready output.
      send(0, 5, 0);
      step();
      chk("rst_out_valid", 64'(s_ov), 64'd0);
      chk("rst_in_ready",  64'(s_ir), 64'd0);
      step();
      chk("rst_busy",       64'(s_busy), 64'd0);
      chk("rst_out_valid2", 64'(s_ov),   64'd0);
      reset = 1'b0;

      // Pass-through, count 0 then 1.
      step();
      chk("pt0_in_ready", 64'(s_ir),   64'd1);
      chk("pt0_xfer",     64'(s_fire), 64'd1);
      send(1, 5, 0);
      step();
      chk("pt1_in_ready", 64'(s_ir),   64'd1);
      chk("pt1_xfer",     64'(s_fire), 64'd1);
      chk("pt1_busy",     64'(s_busy), 64'd0);

      // Expansion: 4 uops, rd 8,10,12,14.
      send(4, 8, 2);
      for (int c = 0; c < 4; c++) begin
         step();
         chk("exp_in_ready", 64'(s_ir),   (c == 0) ? 64'd1 : 64'd0);
         chk("exp_busy",     64'(s_busy), (c != 0) ? 64'd1 : 64'd0);
         chk("exp_xfer",     64'(s_fire), 64'd1);
      end
      step();
      chk("exp_busy_after", 64'(s_busy),    64'd0);
      chk("exp_drained",    64'(sb.size()), 64'd0);

      // Back-to-back with rd wrap: 62,63,0 then 0,3 with no gap.
      send(3, 62, 1);
      send(2, 0, 3);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("b2b_xfer", 64'(s_fire), 64'd1);
      end
      chk("b2b_drained", 64'(sb.size()), 64'd0);

      // Backpressure: out_ready 1,0,0,1,1 gives exactly three transfers.
      rs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      send(3, 40, 5);
      begin
         int x0;
         x0 = n_xfer;
         for (int c = 0; c < 5; c++) begin
            out_ready = rs[c];
            step();
            if (c > 0) begin
               chk("bp_in_ready", 64'(s_ir),   64'd0);
               chk("bp_busy",     64'(s_busy), 64'd1);
               chk("bp_valid",    64'(s_ov),   64'd1);
            end
         end
         chk("bp_xfers", 64'(n_xfer - x0), 64'd3);
      end
      out_ready = 1'b1;

      // Flush while IDLE: the presented instruction is not consumed.
      send(1, 7, 1);
      flush = 1'b1;
      step();
      chk("fli_in_ready",  64'(s_ir), 64'd0);
      chk("fli_out_valid", 64'(s_ov), 64'd0);
      flush = 1'b0;
      step();
      chk("fli_xfer", 64'(s_fire), 64'd1);

      // Flush at idx 3 of an 8-uop sequence; next instruction issues right after.
      send(8, 20, 1);
      repeat (3) step();
      send(1, 33, 0);
      flush = 1'b1;
      step();
      chk("fl_out_valid", 64'(s_ov),   64'd0);
      chk("fl_in_ready",  64'(s_ir),   64'd0);
      chk("fl_busy",      64'(s_busy), 64'd1);
      flush = 1'b0;
      step();
      chk("fl_next_xfer",  64'(s_fire), 64'd1);
      chk("fl_next_ready", 64'(s_ir),   64'd1);
      chk("fl_next_busy",  64'(s_busy), 64'd0);

      // Clamp: count 31 yields 16 uops, last at idx 15.
      send(31, 0, 1);
      for (int c = 0; c < 16; c++) begin
         step();
         chk("clamp_xfer", 64'(s_fire), 64'd1);
      end
      step();
      chk("clamp_idle",    64'(s_busy),    64'd0);
      chk("clamp_drained", 64'(sb.size()), 64'd0);

      // Reset mid-sequence at idx 5, then normal IDLE behaviour.
      send(31, 10, 2);
      repeat (5) step();
      reset = 1'b1;
      step();
      chk("rstm_out_valid", 64'(s_ov),   64'd0);
      chk("rstm_in_ready",  64'(s_ir),   64'd0);
      chk("rstm_busy",      64'(s_busy), 64'd1);
      reset = 1'b0;
      send(2, 3, 1);
      step();
      chk("post_rst_busy",     64'(s_busy), 64'd0);
      chk("post_rst_in_ready", 64'(s_ir),   64'd1);
      chk("post_rst_xfer",     64'(s_fire), 64'd1);
      step();
      chk("post_rst_xfer2", 64'(s_fire), 64'd1);
      step();

      chk("sb_final", 64'(sb.size()), 64'd0);
      chk("iq_final", 64'(iq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vx_uop_expander.md
# VX_uop_expander

Parametrised micro-op sequencer in the per-warp issue path, between the instruction buffer and the scheduler. Each incoming instruction is expanded into 1..MAX_UOPS micro-ops with a running destination-register offset. The first micro-op issues in the acceptance cycle (zero-bubble start), and back-to-back expansions run with no idle cycle. The instruction buffer is released as soon as the first micro-op is accepted, and a synchronous flush aborts an in-flight sequence.

## Interface
Parameters:
- DATA_WIDTH, 64, opaque instruction payload width
- MAX_UOPS, 16, maximum micro-ops per instruction (>=2)
- REG_WIDTH, 6, destination register index width
- STRIDE_WIDTH, 3, register stride width
- CNT_WIDTH, derived $clog2(MAX_UOPS+1), count/index width

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high
- flush  in  1  abort current sequence (synchronous)
- in_valid  in  1  instruction valid
- in_ready  out  1  instruction consumed
- in_data  in  DATA_WIDTH  payload
- in_count  in  CNT_WIDTH  micro-ops requested; 0 and 1 mean pass-through
- in_rd  in  REG_WIDTH  base destination register
- in_stride  in  STRIDE_WIDTH  rd increment per micro-op
- out_valid  out  1  micro-op valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH  payload, copied unchanged
- out_rd  out  REG_WIDTH  in_rd + idx*in_stride mod 2^REG_WIDTH
- out_idx  out  CNT_WIDTH  micro-op index, starting at 0
- out_first  out  1  idx == 0
- out_last  out  1  final micro-op of instruction
- busy  out  1  state == ACTIVE

## Operation
- Effective count N = max(1, min(in_count, MAX_UOPS)). Clamping is silent.
- States: IDLE and ACTIVE. Registers: data_q, rd_q, stride_q, last_idx_q (N-1), idx_q.
- IDLE behaviour:
  - Output is combinational from the input: out_valid=in_valid, out_data=in_data, out_rd=in_rd, out_idx=0, out_first=1, out_last=(N==1).
  - in_ready=out_ready. The input and output fire together.
- IDLE with fire and N>1:
  - Latch data_q, stride_q, last_idx_q=N-1, and rd_q=in_rd+in_stride.
  - Set idx_q=1 and go to ACTIVE.
  - The instruction is consumed in this cycle.
- ACTIVE behaviour:
  - out_valid=1. Output is driven from registers: out_idx=idx_q, out_rd=rd_q, out_first=0, out_last=(idx_q==last_idx_q). in_ready=0.
  - On fire when not last: idx_q+1, rd_q+stride_q (wraps mod 2^REG_WIDTH).
  - On fire when last: go to IDLE. A new instruction presented on the next cycle fires immediately.
- Output stall: all outputs hold stable while out_valid=1 and out_ready=0. There is no output retraction in ACTIVE.
- rd arithmetic is incremental addition only. Stride is zero-extended.
- flush has priority over everything:
  - In the flush cycle: out_valid=0, in_ready=0, no fire.
  - Next cycle: state=IDLE, idx_q=0. The remaining micro-ops are discarded.
  - An IDLE-state input is not consumed during flush.

## Timing
- Reset values: state=IDLE, idx_q=0, busy=0. out_valid=0 and in_ready=0 are forced while reset=1, regardless of in_valid/out_ready.
- Latency: input to first micro-op is 0 cycles (combinational).
- Throughput: 1 micro-op per cycle under continuous out_ready. An N-uop instruction occupies exactly N output cycles.
- in_ready path: in_ready depends combinationally on out_ready in IDLE only.
- Busy timing: busy rises the cycle after the first fire of an N>1 instruction and falls the cycle after the last fire.
- Reset mid-sequence: behaves as flush. No micro-op is emitted in the reset cycle.
- Flush and last-fire in the same cycle: flush wins. The last micro-op is not transferred.

## Test plan
- Pass-through: in_count=0 then 1, in_rd=5, out_ready=1 → one output each with idx=0, first=1, last=1, rd=5, and in_ready=1 in the same cycle.
- Expansion: in_count=4, in_rd=8, in_stride=2, out_ready=1 →
  - Four consecutive outputs with rd 8,10,12,14 and idx 0..3.
  - last=1 only on idx 3.
  - in_ready high only in cycle 0.
  - busy high for cycles 1..3.
- Back-to-back with wrap: REG_WIDTH=6.
  - Instruction A: count=3, rd=62, stride=1. Instruction B: count=2, rd=0, stride=3, held valid.
  - Required: rd sequence 62,63,0, then 0,3, over 5 contiguous cycles with no gap.
- Backpressure: count=3. Toggle out_ready 1,0,0,1,1 → outputs stable during the stall, exactly 3 transfers, in_ready=0 while busy.
- Flush: count=8, flush at idx 3 → no transfer in the flush cycle. The next input (count=1) issues the following cycle with idx=0.
- Clamp/reset: MAX_UOPS=16, in_count=31 → exactly 16 micro-ops, last at idx 15. Assert reset at idx 5 → out_valid=0, then IDLE behaviour.
